// File: rtl/font_text_pkg.sv
// Shared geometry, FSM encoding and cell-slice helper for the 16x12 font text scheduler.
package font_text_pkg;

    localparam int C_COLS   = 16;
    localparam int C_ROWS   = 12;
    localparam int C_CELLS  = C_COLS * C_ROWS;
    localparam int C_CELL_W = 5;
    localparam int C_ADR_W  = 8;
    localparam int C_BUF_W  = C_CELLS * C_CELL_W;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } fsm_t;

    // LSB of cell n inside the flat buffer; bit 4 of each cell is DISP_ON
    function automatic int cell_lsb(input int n);
        return n * C_CELL_W;
    endfunction

endpackage

// File: rtl/font_text_sched_if.sv
// Bundle of the text scheduler's requester, control and display signals.
interface font_text_sched_if;
    import font_text_pkg::*;

    logic                 PX_CK_EE_i;
    logic [10:0]          HCTRs_i;
    logic [10:0]          VCTRs_i;
    logic                 A_REQ_i;
    logic [C_ADR_W-1:0]   A_ADRs_i;
    logic [C_CELL_W-1:0]  A_DATs_i;
    logic                 A_GNT_o;
    logic                 B_REQ_i;
    logic [C_ADR_W-1:0]   B_ADRs_i;
    logic [C_CELL_W-1:0]  B_DATs_i;
    logic                 B_GNT_o;
    logic                 CLR_REQ_i;
    logic                 COMMIT_REQ_i;
    logic                 BUSY_o;
    logic                 COMMIT_PEND_o;
    logic                 FRAME_o;
    logic                 ERR_o;
    logic [C_BUF_W-1:0]   DATss_o;

    modport slave (
        input  PX_CK_EE_i, HCTRs_i, VCTRs_i,
        input  A_REQ_i, A_ADRs_i, A_DATs_i,
        input  B_REQ_i, B_ADRs_i, B_DATs_i,
        input  CLR_REQ_i, COMMIT_REQ_i,
        output A_GNT_o, B_GNT_o, BUSY_o, COMMIT_PEND_o, FRAME_o, ERR_o, DATss_o
    );

    modport master (
        output PX_CK_EE_i, HCTRs_i, VCTRs_i,
        output A_REQ_i, A_ADRs_i, A_DATs_i,
        output B_REQ_i, B_ADRs_i, B_DATs_i,
        output CLR_REQ_i, COMMIT_REQ_i,
        input  A_GNT_o, B_GNT_o, BUSY_o, COMMIT_PEND_o, FRAME_o, ERR_o, DATss_o
    );

endinterface

// File: rtl/font_text_rr_arb.sv
// Two-way round-robin arbiter; grant is combinational, pointer moves only on a grant.
module font_text_rr_arb (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_en,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt
);

    // 1 means B was granted most recently, so A wins the next tie
    logic       r_last_b;
    logic [1:0] w_req;

    assign w_req = i_req & {2{i_en}};

    always_comb begin
        o_gnt = w_req;
        if (w_req == 2'b11)
            o_gnt = r_last_b ? 2'b01 : 2'b10;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_last_b <= 1'b1;
        else if (|o_gnt)
            r_last_b <= o_gnt[1];
    end

endmodule

// File: rtl/font_text_sched.sv
// Shadow/display text buffer scheduler: arbitrated writes, clear sequencer, frame-boundary commit.
// Optional FONT_TEXT_AUTO_COMMIT_EN: commit any dirty shadow at each boundary without a request.
module font_text_sched
    import font_text_pkg::*;
#(
    parameter int              C_COMMIT_LINE = 0,
    parameter logic [4:0]      C_CLR_VAL     = 5'b0_0000
) (
    input logic                CK_i,
    input logic                SRST_i,
    font_text_sched_if.slave   bus
);

    localparam logic [C_ADR_W-1:0] C_LAST_CELL = C_ADR_W'(C_CELLS - 1);

    fsm_t                  r_state, w_state_nxt;
    logic [C_ADR_W-1:0]    r_clr_cnt;
    logic [C_BUF_W-1:0]    r_shadow;
    logic [C_BUF_W-1:0]    r_disp;
    logic                  r_pend;
    logic                  r_frame;
    logic                  r_err;

    logic [1:0]            w_gnt;
    logic                  w_idle;
    logic [C_ADR_W-1:0]    w_wr_adr;
    logic [C_CELL_W-1:0]   w_wr_dat;
    logic                  w_bad;
    logic                  w_sh_we;
    logic [C_ADR_W-1:0]    w_sh_adr;
    logic [C_CELL_W-1:0]   w_sh_dat;
    logic                  w_evt;
    logic                  w_want;
    logic                  w_commit;

    assign w_idle = (r_state == IDLE);

    font_text_rr_arb u_arb (
        .i_clk (CK_i),
        .i_rst (SRST_i),
        .i_en  (w_idle),
        .i_req ({bus.B_REQ_i, bus.A_REQ_i}),
        .o_gnt (w_gnt)
    );

    always_comb begin
        w_wr_adr = bus.A_ADRs_i;
        w_wr_dat = bus.A_DATs_i;
        if (w_gnt[1]) begin
            w_wr_adr = bus.B_ADRs_i;
            w_wr_dat = bus.B_DATs_i;
        end
    end

    assign w_bad = (|w_gnt) && (w_wr_adr > C_LAST_CELL);

    // Single shadow write port: clear and granted writes never overlap
    always_comb begin
        w_sh_we  = 1'b0;
        w_sh_adr = w_wr_adr;
        w_sh_dat = w_wr_dat;
        if (r_state == CLEAR) begin
            w_sh_we  = 1'b1;
            w_sh_adr = r_clr_cnt;
            w_sh_dat = C_CLR_VAL;
        end else if ((|w_gnt) && !w_bad) begin
            w_sh_we  = 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.CLR_REQ_i)           w_state_nxt = CLEAR;
            CLEAR:   if (r_clr_cnt == C_LAST_CELL) w_state_nxt = IDLE;
            default:                               w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CK_i) begin
        if (SRST_i) begin
            r_state   <= IDLE;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= (r_state == CLEAR && r_clr_cnt != C_LAST_CELL) ? r_clr_cnt + 1'b1 : '0;
        end
    end

    always_ff @(posedge CK_i) begin
        if (SRST_i)
            r_shadow <= '0;
        else if (w_sh_we)
            r_shadow[cell_lsb(int'(w_sh_adr)) +: C_CELL_W] <= w_sh_dat;
    end

    assign w_evt = bus.PX_CK_EE_i && (bus.HCTRs_i == 11'd0) &&
                   (bus.VCTRs_i == 11'(C_COMMIT_LINE));

`ifdef FONT_TEXT_AUTO_COMMIT_EN
    logic r_dirty;

    // A write landing in the commit cycle is not in the copy, so it keeps dirty set
    always_ff @(posedge CK_i) begin
        if (SRST_i)
            r_dirty <= 1'b0;
        else
            r_dirty <= w_sh_we || (r_dirty && !w_commit);
    end

    assign w_want = r_pend || bus.COMMIT_REQ_i || r_dirty;
`else
    assign w_want = r_pend || bus.COMMIT_REQ_i;
`endif

    // Copy uses the pre-edge shadow, so a same-cycle write waits for the next commit
    assign w_commit = w_evt && w_idle && w_want;

    always_ff @(posedge CK_i) begin
        if (SRST_i) begin
            r_disp  <= '0;
            r_pend  <= 1'b0;
            r_frame <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            if (w_commit)
                r_disp <= r_shadow;
            if (w_commit)
                r_pend <= 1'b0;
            else if (bus.COMMIT_REQ_i)
                r_pend <= 1'b1;
            r_frame <= w_commit;
            r_err   <= r_err || w_bad;
        end
    end

    assign bus.A_GNT_o       = w_gnt[0];
    assign bus.B_GNT_o       = w_gnt[1];
    assign bus.BUSY_o        = (r_state == CLEAR);
    assign bus.COMMIT_PEND_o = r_pend;
    assign bus.FRAME_o       = r_frame;
    assign bus.ERR_o         = r_err;
    assign bus.DATss_o       = r_disp;

endmodule

// File: doc/font_text_sched.md
Name: font_text_sched

Overview:
Scheduler and arbiter for the 16x12 character text buffer that drives the 5x7 font overlay.
- Two write requesters (host loader, internal status writer) share one shadow buffer.
- A clear sequencer can blank the whole shadow buffer.
- Shadow contents are committed to the displayed buffer only at a programmable frame boundary, so the overlay never tears mid-frame.
- DATss_o connects directly to the font overlay's character-data input.

Parameters:
C_COMMIT_LINE, 0, VCTRs_i value whose first pixel (HCTRs_i==0) is the frame-boundary commit point.
C_CLR_VAL, 5'b0_0000, cell value written by the clear sequencer.

Ports:
CK_i  in  1  system clock
SRST_i  in  1  synchronous reset, active high
PX_CK_EE_i  in  1  pixel clock enable; qualifies the frame-boundary event
HCTRs_i  in  11  horizontal pixel counter
VCTRs_i  in  11  vertical line counter
A_REQ_i  in  1  requester A write request (host)
A_ADRs_i  in  8  requester A cell address, row*16+col
A_DATs_i  in  5  requester A cell data {DISP_ON, HEX[3:0]}
A_GNT_o  out  1  requester A grant
B_REQ_i, B_ADRs_i, B_DATs_i, B_GNT_o  same as A, for requester B (internal)
CLR_REQ_i  in  1  start the shadow clear sequence
COMMIT_REQ_i  in  1  request a shadow-to-display copy at the next boundary
BUSY_o  out  1  clear sequence in progress
COMMIT_PEND_o  out  1  commit requested, not yet done
FRAME_o  out  1  one-CK pulse when a commit executes
ERR_o  out  1  sticky: granted write carried address >= 192
DATss_o  out  960  displayed buffer; cell n at [5n+4:5n], bit 4 = DISP_ON

Behaviour:
- Reset (SRST_i high at CK edge):
  - shadow and display buffers all 0 (DATss_o = 0, blank screen);
  - A_GNT_o, B_GNT_o, BUSY_o, COMMIT_PEND_o, FRAME_o, ERR_o = 0;
  - FSM = IDLE; round-robin pointer favours A.
  - Reset mid-clear or with a commit pending aborts both.
- Write handshake:
  - Requester holds REQ, ADR and DAT stable until it sees GNT.
  - GNT is combinational, high in the cycle the write is accepted.
  - Shadow cell is updated at that CK edge. At most one write per CK.
  - REQ may stay high for back-to-back writes.
- Arbitration: two-way round-robin.
  - When both request, the requester not granted last wins; a single requester always wins.
  - The pointer updates only on a grant.
- Bad address: ADR >= 192 is granted and dropped; ERR_o sets and stays set until reset.
- FSM IDLE -> CLEAR:
  - Triggered by CLR_REQ_i in IDLE.
  - In CLEAR, an 8-bit counter walks cells 0..191, writing C_CLR_VAL one cell per CK (192 cycles).
  - At count 191, FSM returns to IDLE.
  - BUSY_o is high for exactly those 192 cycles. No GNT is issued during CLEAR; CLR_REQ_i is ignored.
- Frame boundary event: PX_CK_EE_i & (HCTRs_i==0) & (VCTRs_i==C_COMMIT_LINE).
- Commit:
  - COMMIT_REQ_i sets COMMIT_PEND_o.
  - At a boundary event with (pending | COMMIT_REQ_i) and FSM==IDLE, the whole shadow is copied to the display register in one CK.
  - That CK also clears pending and pulses FRAME_o.
  - A write granted in the same CK lands in shadow only; the copy uses the pre-write value.
  - If FSM==CLEAR at the event, the commit defers to the next event.
- DATss_o changes only on commit or reset.

Optional Feature:
FONT_TEXT_AUTO_COMMIT_EN
- Defined:
  - A dirty flag is set by any shadow write (granted write or clear cell).
  - Every boundary event in IDLE with dirty set commits as if COMMIT_REQ_i were high, then clears dirty.
  - COMMIT_REQ_i still works.
- Undefined: commits occur only on explicit request; no dirty logic is built.

Decomposition:
- Package font_text_pkg:
  - C_COLS=16, C_ROWS=12, C_CELLS=192, C_CELL_W=5, C_ADR_W=8;
  - FSM state enum {IDLE, CLEAR};
  - cell slice helper (5n offset).
- Sub-module font_text_rr_arb: two-way round-robin arbiter with REQ pair in, GNT pair out, and an internal last-grant pointer.

Test Plan:
- Reset, then idle 2 frames -> DATss_o=0, FRAME_o never pulses, ERR_o=0.
- A writes adr 17 data 5'h1A, COMMIT_REQ_i, run to line C_COMMIT_LINE -> A_GNT_o 1 CK; DATss_o[89:85]=5'h1A only after the FRAME_o pulse; COMMIT_PEND_o clears.
- A and B request continuously (adr 0/1) -> grants alternate A,B,A,B…; with A only, A is granted every CK.
- CLR_REQ_i, then A_REQ_i -> BUSY_o high 192 CK; A_GNT_o withheld until BUSY_o falls; a commit event during CLEAR is deferred one frame.
- B writes adr 200 -> B_GNT_o pulses, shadow unchanged, ERR_o=1 until reset.
- Write and boundary event in the same CK -> display shows the old value; the new value appears at the next commit. With FONT_TEXT_AUTO_COMMIT_EN defined, that next commit occurs without COMMIT_REQ_i.
